// File: rtl/range_info_loader.sv
// range_info_loader
//   Parses a byte stream (one byte per range, range 0 first) into packed
//   range_info records. Each record is checked for consistency and good
//   records are presented through a one-deep output register with a
//   valid/take handshake. Bad records are dropped and raise a sticky error.
//
// Ports
//   CLK              : clock
//   reset            : asynchronous, active-high reset
//   in_data[7:0]     : range byte, bit 7 = active, bits 6:0 = position
//   in_valid         : in_data is valid
//   in_ready         : loader accepts a byte this cycle
//   range_info       : packed record, range i in field i, field MSB = active
//   range_info_valid : output register holds a record
//   range_info_rd_en : consumer takes the held record
//   range_count      : number of active ranges in the held record
//   err              : sticky record-format error
module range_info_loader #(
  parameter int WORD_MAX_LEN   = 32,
  parameter int RANGES_MAX     = 4,
  parameter int RANGE_INFO_MSB = $clog2(WORD_MAX_LEN)
) (
  input  logic                                      CLK,
  input  logic                                      reset,
  input  logic [7:0]                                in_data,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0]  range_info,
  output logic                                      range_info_valid,
  input  logic                                      range_info_rd_en,
  output logic [$clog2(RANGES_MAX+1)-1:0]           range_count,
  output logic                                      err
);

  localparam int PW = RANGE_INFO_MSB;
  localparam int FW = RANGE_INFO_MSB + 1;
  localparam int RW = RANGES_MAX * FW;
  localparam int CW = $clog2(RANGES_MAX + 1);
  localparam int IW = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg;
  logic [RW-1:0]   asm_info_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   prev_pos_reg;
  logic            seen_inactive_reg;
  logic            bad_reg;

  logic            accept;
  logic            active;
  logic [PW-1:0]   pos;
  logic [FW-1:0]   slot_val;
  logic            byte_bad;
  logic            last;
  logic            rec_done;
  logic            rec_bad;
  logic            rec_good;
  logic            slot_free;
  logic            transfer;
  logic [RW-1:0]   rec_info;
  logic [CW-1:0]   rec_count;
  logic [RW-1:0]   xfer_info;
  logic [CW-1:0]   xfer_count;

  // ---------------- byte decode and checks ----------------
  assign accept   = in_valid && in_ready;
  assign active   = in_data[7];
  assign pos      = in_data[PW-1:0];
  assign slot_val = active ? {1'b1, pos} : '0;

  // count_reg != 0 means an earlier active range exists to compare against.
  assign byte_bad = active &&
                    (({25'd0, in_data[6:0]} >= 32'(WORD_MAX_LEN)) ||
                     seen_inactive_reg ||
                     ((count_reg != '0) && (pos <= prev_pos_reg)));

  assign last      = (idx_reg == IW'(RANGES_MAX - 1));
  assign rec_done  = accept && last;
  assign rec_bad   = bad_reg || byte_bad;
  assign rec_good  = rec_done && !rec_bad;
  assign rec_count = count_reg + CW'(active);
  assign slot_free = !range_info_valid || range_info_rd_en;

  // Assembly buffer with the current byte's slot substituted in; on the
  // last byte this is the complete record.
  genvar gi;
  generate
    for (gi = 0; gi < RANGES_MAX; gi++) begin : g_slot
      assign rec_info[gi*FW +: FW] = (idx_reg == IW'(gi)) ? slot_val
                                                          : asm_info_reg[gi*FW +: FW];
    end
  endgenerate

  // A held record (HOLD) lives entirely in the assembly registers.
  assign transfer   = ((state_reg == LOAD) && rec_good && slot_free) ||
                      ((state_reg == HOLD) && slot_free);
  assign xfer_info  = (state_reg == HOLD) ? asm_info_reg : rec_info;
  assign xfer_count = (state_reg == HOLD) ? count_reg    : rec_count;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_reg <= LOAD;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (rec_good && !slot_free) state_next = HOLD;
      HOLD:    if (slot_free)              state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (state_reg == LOAD);
  end

  // ---------------- record assembly ----------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idx_reg           <= '0;
      asm_info_reg      <= '0;
      count_reg         <= '0;
      prev_pos_reg      <= '0;
      seen_inactive_reg <= 1'b0;
      bad_reg           <= 1'b0;
    end else if (accept) begin
      asm_info_reg <= rec_info;
      if (last) begin
        idx_reg           <= '0;
        prev_pos_reg      <= '0;
        seen_inactive_reg <= 1'b0;
        bad_reg           <= 1'b0;
        // Keep the count only if the finished record must wait in HOLD.
        count_reg         <= (rec_good && !slot_free) ? rec_count : '0;
      end else begin
        idx_reg           <= idx_reg + IW'(1);
        bad_reg           <= rec_bad;
        seen_inactive_reg <= seen_inactive_reg || !active;
        count_reg         <= rec_count;
        if (active) prev_pos_reg <= pos;
      end
    end else if ((state_reg == HOLD) && transfer) begin
      count_reg <= '0;
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      range_info       <= '0;
      range_count      <= '0;
      range_info_valid <= 1'b0;
      err              <= 1'b0;
    end else begin
      if (transfer) begin
        range_info       <= xfer_info;
        range_count      <= xfer_count;
        range_info_valid <= 1'b1;
      end else if (range_info_rd_en) begin
        range_info_valid <= 1'b0;
      end
      if (rec_done && rec_bad) err <= 1'b1;
    end
  end

endmodule

// File: doc/range_info_loader.md
# range_info_loader

Producer side of the range-info word consumed by the word generator's range decode. It parses a byte stream from the packet-communication input (one byte per range, range 0 first), checks each record for consistency, and packs it into the `range_info` bus format. It presents each record to the generator through a one-deep output register with a valid/take handshake, so the next record can be assembled while the current one is held.

## Interface
- `WORD_MAX_LEN`, 32, maximum word length in characters.
- `RANGES_MAX`, 4, number of ranges per record.
- `RANGE_INFO_MSB`, 1+`MSB(WORD_MAX_LEN-1)`, width of the position field. Must be ≤ 7.
- `CLK` input 1: single clock.
- `reset` input 1: asynchronous, active-high.
- `in_data` input 8: range byte. Bit 7 = active; bits 6:0 = new position.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `range_info` output RANGES_MAX*(RANGE_INFO_MSB+1): packed record.
  - Range i occupies bits [(i+1)*(RANGE_INFO_MSB+1)-1 -: RANGE_INFO_MSB+1].
  - Within a range: MSB = active, remaining bits = position.
- `range_info_valid` output 1: output register holds a record.
- `range_info_rd_en` input 1: consumer takes the record.
- `range_count` output `MSB(RANGES_MAX)`+1: number of active ranges in the held record.
- `err` output 1: sticky record-format error.

## Operation
- A byte is accepted when `in_valid` and `in_ready` are both high.
- Index counter `idx` runs 0..RANGES_MAX-1. Byte at index `idx` fills assembly slot `idx`.
- Active byte: slot = {1, in_data[RANGE_INFO_MSB-1:0]}.
- Inactive byte: slot = 0. The position bits of an inactive byte are ignored.
- Per-byte checks. Each one sets the record-bad flag `bad`:
  - Active byte with in_data[6:0] ≥ WORD_MAX_LEN.
  - Active byte after an inactive byte in the same record (active ranges must be contiguous from range 0).
  - Active byte whose position ≤ the previous active range's position. Positions must be strictly increasing, which guarantees no collisions and position ≥ index.
- The active count increments on each active byte.
- State LOAD: `in_ready`=1.
  - When the last byte (idx=RANGES_MAX-1) is accepted, `idx` wraps to 0. The per-record flags (`bad`, prev position, seen-inactive, count) clear.
  - If the record is good: it transfers to the output register when the slot is free (`range_info_valid`=0, or `range_info_rd_en`=1 in the same cycle). Otherwise go to HOLD.
  - If the record is bad: it is discarded, `err` is set, and the state stays LOAD.
- State HOLD: `in_ready`=0. Transfer when `range_info_valid`=0 or `range_info_rd_en`=1, then return to LOAD.
- The output register updates `range_info` and `range_count` only on transfer.
- `range_info_valid` clears on `range_info_rd_en` unless a transfer occurs in the same cycle.
- `range_info_rd_en` while `range_info_valid`=0 is ignored.
- `err` stays set until reset. Loading continues after an error.

## Timing
- Reset values:
  - `range_info`=0, `range_info_valid`=0, `range_count`=0, `err`=0.
  - State LOAD, `idx`=0, so `in_ready`=1 from the first cycle after reset deasserts.
- Latency: last byte accepted at cycle t with the slot free → `range_info_valid`=1 at t+1.
- Latency from HOLD: `range_info_rd_en` at cycle t → new record valid at t+1, and `in_ready`=1 at t+1.
- Bad record: `err`=1 at t+1 after the last byte is accepted. `range_info_valid` is unchanged.
- Throughput: one byte per cycle. Back-to-back records are possible if the consumer takes each record within RANGES_MAX cycles.
- `in_ready` is a function of state only, with no combinational path from `in_valid`.
- Reset asserted mid-record or in HOLD: the partial or held record is lost and all outputs return to reset values.

## Test plan
- RANGES_MAX=4, WORD_MAX_LEN=32, bytes 0x80,0x83,0x00,0x00 → at the next cycle `range_info`=0x0008E0, `range_count`=2, `range_info_valid`=1, `err`=0.
- Bytes 0x85,0x84,0x00,0x00 (non-increasing positions) → `err`=1 one cycle after the 4th byte, `range_info_valid` stays 0. The next good record 0x81,0x00,0x00,0x00 then appears with `range_info`=0x000021.
- Bytes 0xA0,0,0,0 (position 32) → `err`=1. Bytes 0x00,0x81,0,0 (gap) → `err`=1.
- Two good records streamed with `range_info_rd_en` held low:
  - The first record appears.
  - `in_ready`=0 after the 8th byte.
  - Pulse `range_info_rd_en` → the second record appears the next cycle and `in_ready`=1.
- `range_info_rd_en` in the same cycle the last byte of the next record is accepted → the new record is presented at t+1 with `range_info_valid` continuously 1.
- Assert `reset` after 2 bytes of a record, then send a full record → only the full record is output, with correct packing.
